// File: rtl/esm_issue_scheduler_if.sv
// Fetch-side and issue-side signals of the ESM issue scheduler.
// The master drives the instruction stream, and the slave is the scheduler itself.
interface esm_issue_scheduler_if #(
  parameter int IW = 32,
  parameter int BS = 16
);
  localparam int IDXW = $clog2(BS);

  logic [IW-1:0]   instr_in;
  logic            in_valid;
  logic            reg_write_in;
  logic            alu_src_in;
  logic            in_ready;
  logic [IW-1:0]   instr_out;
  logic            issue_valid;
  logic [IDXW-1:0] issue_index;
  logic [IDXW:0]   valid_count;
  logic            busy;

  modport master (
    output instr_in, in_valid, reg_write_in, alu_src_in,
    input  in_ready, instr_out, issue_valid, issue_index, valid_count, busy
  );

  modport slave (
    input  instr_in, in_valid, reg_write_in, alu_src_in,
    output in_ready, instr_out, issue_valid, issue_index, valid_count, busy
  );
endinterface

// File: rtl/esm_issue_scheduler.sv
// Dependency-aware issue controller for the ESM instruction buffer.
// FILL loads the buffer in order. DRAIN issues the lowest-index entry that is
// free of RAW, WAR and WAW hazards against older entries, and that has no
// source still pending in the writeback scoreboard.
module esm_issue_scheduler #(
  parameter int IW     = 32,
  parameter int BS     = 16,
  parameter int WB_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  esm_issue_scheduler_if.slave bus
);
  localparam int IDXW = $clog2(BS);
  localparam int CW   = IDXW + 1;

  typedef enum logic {FILL, DRAIN} state_e;

  state_e            state_q;
  logic [IW-1:0]     instr_q [BS];
  logic [BS-1:0]     vld_q;
  logic [BS-1:0]     rw_q;
  logic [BS-1:0]     alu_q;
  logic [CW-1:0]     cnt_q;
  logic [WB_LAT-1:0] sb_v_q;
  logic [4:0]        sb_rd_q [WB_LAT];
  logic [IW-1:0]     instr_out_q;
  logic              issue_valid_q;
  logic [IDXW-1:0]   issue_index_q;

  logic              in_ready_c;
  logic [31:0]       pend_c;
  logic              sb_empty_c;
  logic [BS-1:0]     elig_c;
  logic              haz_c;
  logic              sel_found_c;
  logic [IDXW-1:0]   sel_idx_c;
  logic [IW-1:0]     sel_instr_c;
  logic [4:0]        sel_rd_c;
  logic              sel_wr_c;

  function automatic logic [4:0] f_rd(input logic [IW-1:0] x);
    return x[11:7];
  endfunction

  function automatic logic [4:0] f_rs1(input logic [IW-1:0] x);
    return x[19:15];
  endfunction

  function automatic logic [4:0] f_rs2(input logic [IW-1:0] x);
    return x[24:20];
  endfunction

  // An instruction reads r through rs1, and through rs2 only when rs2 is not replaced by an immediate.
  function automatic logic f_reads(input logic [IW-1:0] x, input logic alu,
                                   input logic [4:0] r);
    return (f_rs1(x) == r) || (!alu && (f_rs2(x) == r));
  endfunction

  assign in_ready_c = (state_q == FILL) && (cnt_q < CW'(BS));

  // Decode the scoreboard into a per-register pending mask. x0 is never pending.
  always_comb begin
    pend_c = '0;
    for (int unsigned s = 0; s < WB_LAT; s++) begin
      if (sb_v_q[s]) pend_c[sb_rd_q[s]] = 1'b1;
    end
    pend_c[0]  = 1'b0;
    sb_empty_c = ~|sb_v_q;
  end

  // Per-entry hazard check against older valid entries and the scoreboard.
  // Then pick the lowest-index eligible entry.
  always_comb begin
    elig_c      = '0;
    haz_c       = 1'b0;
    sel_found_c = 1'b0;
    sel_idx_c   = '0;
    for (int unsigned e = 0; e < BS; e++) begin
      haz_c = pend_c[f_rs1(instr_q[e])] ||
              (!alu_q[e] && pend_c[f_rs2(instr_q[e])]);
      for (int unsigned j = 0; j < BS; j++) begin
        if (j < e && vld_q[j]) begin
          if (rw_q[j] && f_rd(instr_q[j]) != 5'd0 &&
              f_reads(instr_q[e], alu_q[e], f_rd(instr_q[j])))
            haz_c = 1'b1;
          if (rw_q[e] && f_rd(instr_q[e]) != 5'd0 &&
              (f_reads(instr_q[j], alu_q[j], f_rd(instr_q[e])) ||
               (rw_q[j] && f_rd(instr_q[j]) == f_rd(instr_q[e]))))
            haz_c = 1'b1;
        end
      end
      elig_c[e] = vld_q[e] && !haz_c;
    end
    for (int unsigned e = 0; e < BS; e++) begin
      if (elig_c[e] && !sel_found_c) begin
        sel_found_c = 1'b1;
        sel_idx_c   = IDXW'(e);
      end
    end
  end

  assign sel_instr_c = instr_q[sel_idx_c];
  assign sel_wr_c    = rw_q[sel_idx_c];
  assign sel_rd_c    = f_rd(sel_instr_c);

  // FILL/DRAIN state machine with registered issue outputs and the scoreboard shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FILL;
      vld_q         <= '0;
      rw_q          <= '0;
      alu_q         <= '0;
      cnt_q         <= '0;
      sb_v_q        <= '0;
      instr_out_q   <= '0;
      issue_valid_q <= 1'b0;
      issue_index_q <= '0;
      for (int unsigned s = 0; s < WB_LAT; s++) sb_rd_q[s] <= '0;
      for (int unsigned b = 0; b < BS; b++) instr_q[b] <= '0;
    end else begin
      for (int unsigned s = 1; s < WB_LAT; s++) begin
        sb_v_q[s]  <= sb_v_q[s-1];
        sb_rd_q[s] <= sb_rd_q[s-1];
      end
      sb_v_q[0]     <= 1'b0;
      sb_rd_q[0]    <= '0;
      issue_valid_q <= 1'b0;
      instr_out_q   <= '0;
      issue_index_q <= '0;
      unique case (state_q)
        FILL: begin
          if (bus.in_valid && in_ready_c) begin
            if (|bus.instr_in) begin
              instr_q[cnt_q[IDXW-1:0]] <= bus.instr_in;
              rw_q[cnt_q[IDXW-1:0]]    <= bus.reg_write_in;
              alu_q[cnt_q[IDXW-1:0]]   <= bus.alu_src_in;
              vld_q[cnt_q[IDXW-1:0]]   <= 1'b1;
              cnt_q                    <= cnt_q + CW'(1);
              if (cnt_q == CW'(BS - 1)) state_q <= DRAIN;
            end else if (cnt_q != '0) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (sel_found_c) begin
            instr_out_q      <= sel_instr_c;
            issue_valid_q    <= 1'b1;
            issue_index_q    <= sel_idx_c;
            vld_q[sel_idx_c] <= 1'b0;
            cnt_q            <= cnt_q - CW'(1);
            if (sel_wr_c && sel_rd_c != 5'd0) begin
              sb_v_q[0]  <= 1'b1;
              sb_rd_q[0] <= sel_rd_c;
            end
          end else if (cnt_q == '0 && sb_empty_c) begin
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.instr_out   = instr_out_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_index = issue_index_q;
  assign bus.valid_count = cnt_q;
  assign bus.busy        = (state_q == DRAIN);
endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Bench for esm_issue_scheduler: an in-order buffer and a time-stamped write list
// act as the reference model. Every cycle is compared against the model, and
// directed sequences check issue order and spacing.
module tb_esm_issue_scheduler;
  localparam int IW = 32, BS = 16, WB_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  esm_issue_scheduler_if #(.IW(IW), .BS(BS)) bus ();
  esm_issue_scheduler #(.IW(IW), .BS(BS), .WB_LAT(WB_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
  endfunction

  // Reference model: ordered slots plus a list of (rd, cycle issue_valid was seen).
  typedef struct { int rd; int cyc; } wr_t;
  logic [IW-1:0] m_ins [BS];
  bit m_rw [BS], m_alu [BS], m_vld [BS];
  int m_cnt;
  bit m_drain;
  wr_t m_wr[$];
  int cyc = 0;
  int iss_c[$], iss_i[$];

  function automatic int rd_of(input logic [IW-1:0] x);  return int'(x[11:7]);  endfunction
  function automatic int rs1_of(input logic [IW-1:0] x); return int'(x[19:15]); endfunction
  function automatic int rs2_of(input logic [IW-1:0] x); return int'(x[24:20]); endfunction

  function automatic bit m_reads(input int e, input int r);
    return r == rs1_of(m_ins[e]) || (!m_alu[e] && r == rs2_of(m_ins[e]));
  endfunction

  function automatic bit m_pending(input int r);
    if (r == 0) return 0;
    foreach (m_wr[k]) if (m_wr[k].rd == r && cyc - m_wr[k].cyc < WB_LAT) return 1;
    return 0;
  endfunction

  function automatic bit m_any_pending();
    foreach (m_wr[k]) if (cyc - m_wr[k].cyc < WB_LAT) return 1;
    return 0;
  endfunction

  function automatic bit m_elig(input int e);
    int rde;
    if (!m_vld[e]) return 0;
    rde = rd_of(m_ins[e]);
    for (int j = 0; j < e; j++) begin
      if (!m_vld[j]) continue;
      if (m_rw[j] && rd_of(m_ins[j]) != 0 && m_reads(e, rd_of(m_ins[j]))) return 0;
      if (m_rw[e] && rde != 0 && (m_reads(j, rde) || (m_rw[j] && rd_of(m_ins[j]) == rde)))
        return 0;
    end
    if (m_pending(rs1_of(m_ins[e]))) return 0;
    if (!m_alu[e] && m_pending(rs2_of(m_ins[e]))) return 0;
    return 1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < BS; i++) m_vld[i] = 0;
    m_cnt = 0;
    m_drain = 0;
    m_wr.delete();
  endfunction

  // One clock with the given inputs. Called at posedge+1 and returns at the next posedge+1.
  task automatic step(input bit v, input logic [IW-1:0] ins, input bit rw, input bit alu);
    bit rdy, e_iv;
    int sel, e_idx;
    logic [IW-1:0] e_out;
    bus.in_valid = v; bus.instr_in = ins; bus.reg_write_in = rw; bus.alu_src_in = alu;
    rdy = !m_drain && m_cnt < BS;
    chk("in_ready", bus.in_ready, rdy);
    e_iv = 0; e_idx = 0; e_out = '0;
    if (!m_drain) begin
      if (v && rdy) begin
        if (ins != 0) begin
          m_ins[m_cnt] = ins; m_rw[m_cnt] = rw; m_alu[m_cnt] = alu; m_vld[m_cnt] = 1;
          m_cnt++;
          if (m_cnt == BS) m_drain = 1;
        end else if (m_cnt > 0) begin
          m_drain = 1;
        end
      end
    end else begin
      sel = -1;
      for (int e = 0; e < BS; e++) if (sel < 0 && m_elig(e)) sel = e;
      if (sel >= 0) begin
        e_iv = 1; e_idx = sel; e_out = m_ins[sel];
        m_vld[sel] = 0; m_cnt--;
        if (m_rw[sel] && rd_of(m_ins[sel]) != 0) m_wr.push_back('{rd_of(m_ins[sel]), cyc + 1});
      end else if (m_cnt == 0 && !m_any_pending()) begin
        m_drain = 0;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("issue_valid", bus.issue_valid, e_iv);
    if (e_iv) chk("issue_index", bus.issue_index, e_idx);
    chk("instr_out", bus.instr_out, e_out);
    chk("valid_count", bus.valid_count, m_cnt);
    chk("busy", bus.busy, m_drain);
  endtask

  // Idle until the scheduler leaves DRAIN, recording each issue relative to the first drain cycle.
  task automatic run_drain();
    iss_c.delete(); iss_i.delete();
    for (int n = 0; n < 200; n++) begin
      step(0, '0, 0, 0);
      if (bus.issue_valid) begin iss_c.push_back(n); iss_i.push_back(int'(bus.issue_index)); end
      if (!bus.busy) break;
    end
    chk("drain_done", bus.busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_issue_valid", bus.issue_valid, 0);
    chk("rst_instr_out", bus.instr_out, 0);
    chk("rst_valid_count", bus.valid_count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] i0; bit rw0, alu0;
    logic [31:0] i1; bit rw1, alu1;
    int gap;
  } pair_t;
  pair_t tbl [6];

  initial begin
    tbl[0] = '{mk(5,1,2), 1, 0, mk(6,5,3), 1, 0, WB_LAT + 1}; // RAW through rs1
    tbl[1] = '{mk(5,1,2), 1, 0, mk(6,3,5), 1, 0, WB_LAT + 1}; // RAW through rs2
    tbl[2] = '{mk(5,1,2), 1, 0, mk(6,3,5), 1, 1, 1};          // rs2 is an immediate
    tbl[3] = '{mk(0,1,2), 1, 0, mk(6,0,0), 1, 0, 1};          // x0 is never pending
    tbl[4] = '{mk(9,5,2), 0, 0, mk(5,1,2), 1, 0, 1};          // WAR
    tbl[5] = '{mk(5,1,2), 1, 0, mk(5,3,4), 1, 0, 1};          // WAW

    bus.in_valid = 0; bus.instr_in = '0; bus.reg_write_in = 0; bus.alu_src_in = 0;
    m_reset();
    #2;
    do_reset();

    // 16 independent ADDIs fill the buffer and issue back to back.
    for (int i = 0; i < BS; i++) step(1, mk(i + 1, 0, 0), 1, 1);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_busy", bus.busy, 1);
    run_drain();
    chk("addi_count", iss_i.size(), BS);
    for (int k = 0; k < iss_i.size(); k++) begin
      chk("addi_index", iss_i[k], k);
      chk("addi_spacing", iss_c[k] - iss_c[0], k);
    end
    chk("refill_ready", bus.in_ready, 1);

    // Pairwise hazard table.
    foreach (tbl[t]) begin
      step(1, tbl[t].i0, tbl[t].rw0, tbl[t].alu0);
      step(1, tbl[t].i1, tbl[t].rw1, tbl[t].alu1);
      step(1, '0, 0, 0);
      run_drain();
      chk("pair_count", iss_i.size(), 2);
      if (iss_i.size() == 2) begin
        chk("pair_first", iss_i[0], 0);
        chk("pair_second", iss_i[1], 1);
        chk("pair_gap", iss_c[1] - iss_c[0], tbl[t].gap);
      end
    end

    // An independent younger entry slips past a stalled dependent.
    step(1, mk(5,1,2), 1, 0);
    step(1, mk(6,5,3), 1, 0);
    step(1, mk(7,8,9), 1, 0);
    step(1, '0, 0, 0);
    run_drain();
    chk("ooo_count", iss_i.size(), 3);
    if (iss_i.size() == 3) begin
      chk("ooo_order0", iss_i[0], 0);
      chk("ooo_order1", iss_i[1], 2);
      chk("ooo_order2", iss_i[2], 1);
      chk("ooo_gap1", iss_c[1] - iss_c[0], 1);
      chk("ooo_gap2", iss_c[2] - iss_c[0], WB_LAT + 1);
    end

    // Reset two cycles into DRAIN with 10 entries.
    for (int i = 0; i < 10; i++) step(1, mk(i + 1, 0, 0), 1, 1);
    step(1, '0, 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0);

    // End-of-stream with an empty buffer stays in FILL.
    step(1, '0, 0, 0);
    chk("eos_empty_busy", bus.busy, 0);
    chk("eos_empty_ready", bus.in_ready, 1);
    chk("eos_empty_issue", bus.issue_valid, 0);

    // Randomized traffic with a small register set to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      logic [IW-1:0] ins;
      ins = ($urandom_range(0, 11) == 0) ? '0 :
            mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      step($urandom_range(0, 9) < 7, ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
